// File: rtl/agex_stage_pkg.sv
// agex_stage_pkg: encodings and types shared by AGEX and its neighbours.
//   - internal opcode encodings (OP_ADD .. OP_REMU) and the div-class predicate
//   - divider FSM state type
//   - AGEX latch layout; field order matches the MEM_STAGE unpack order
package agex_stage_pkg;

    localparam int DBITS     = 32;
    localparam int REGNOBITS = 5;
    localparam int IOPBITS   = 5;
    localparam int INSTBITS  = 32;

    typedef enum logic [IOPBITS-1:0] {
        OP_NOP   = 5'd0,
        OP_ADD   = 5'd1,
        OP_SUB   = 5'd2,
        OP_AND   = 5'd3,
        OP_OR    = 5'd4,
        OP_XOR   = 5'd5,
        OP_SLT   = 5'd6,
        OP_SLTU  = 5'd7,
        OP_SLL   = 5'd8,
        OP_SRL   = 5'd9,
        OP_SRA   = 5'd10,
        OP_LUI   = 5'd11,
        OP_AUIPC = 5'd12,
        OP_LW    = 5'd13,
        OP_SW    = 5'd14,
        OP_BEQ   = 5'd15,
        OP_BNE   = 5'd16,
        OP_BLT   = 5'd17,
        OP_BGE   = 5'd18,
        OP_BLTU  = 5'd19,
        OP_BGEU  = 5'd20,
        OP_JAL   = 5'd21,
        OP_JALR  = 5'd22,
        OP_DIV   = 5'd23,
        OP_DIVU  = 5'd24,
        OP_REM   = 5'd25,
        OP_REMU  = 5'd26
    } op_e;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    // Field order is the MEM_STAGE unpack order, MSB first.
    typedef struct packed {
        logic                 valid;
        logic [INSTBITS-1:0]  inst;
        logic [DBITS-1:0]     pc;
        logic [IOPBITS-1:0]   op;
        logic [DBITS-1:0]     inst_count;
        logic [DBITS-1:0]     aluout;
        logic [DBITS-1:0]     memaddr;
        logic [DBITS-1:0]     wr_val;
        logic                 wr_mem;
        logic                 rd_mem;
        logic [REGNOBITS-1:0] rd;
        logic                 wr_reg;
    } agex_latch_t;

    localparam int AGEX_LATCH_W = $bits(agex_latch_t);

    function automatic logic is_div_op(input logic [IOPBITS-1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/agex_divider.sv
// agex_divider: iterative restoring divider, one quotient bit per cycle.
//   clk, rst_n   clock, async active-low reset
//   start        begin a division (sampled only in IDLE)
//   signed_op    operands are two's complement (DIV/REM)
//   dividend     operand A, divisor operand B (held stable by the caller)
//   busy         iterating
//   done         quotient/remainder valid this cycle (one cycle, then IDLE)
//   quotient     fixed-up quotient, remainder fixed-up remainder
module agex_divider
    import agex_stage_pkg::*;
#(
    parameter int DBITS     = 32,
    parameter int DIV_ITERS = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [DBITS-1:0] dividend,
    input  logic [DBITS-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DBITS-1:0] quotient,
    output logic [DBITS-1:0] remainder
);
    localparam int CNT_W = $clog2(DIV_ITERS);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DBITS-1:0] quo_q, quo_d;   // dividend shifts out, quotient shifts in
    logic [DBITS-1:0] rem_q, rem_d;
    logic [DBITS-1:0] dsr_q, dsr_d;   // |divisor|
    logic [DBITS-1:0] dvd_q, dvd_d;   // raw dividend, for the divide-by-zero remainder
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             dz_q, dz_d;
    logic             ovf_q, ovf_d;

    logic             a_neg, b_neg;
    logic [DBITS-1:0] abs_a, abs_b;
    logic [DBITS:0]   rem_shift, rem_diff;

    assign a_neg = signed_op & dividend[DBITS-1];
    assign b_neg = signed_op & divisor[DBITS-1];
    assign abs_a = a_neg ? -dividend : dividend;
    assign abs_b = b_neg ? -divisor  : divisor;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dsr_d   = dsr_q;
        dvd_d   = dvd_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        dz_d    = dz_q;
        ovf_d   = ovf_q;
        rem_shift = {rem_q, quo_q[DBITS-1]};
        // Partial remainder is always < divisor, so bit DBITS of the
        // difference is a clean borrow/sign flag.
        rem_diff  = rem_shift - {1'b0, dsr_q};
        unique case (state_q)
            DIV_IDLE: begin
                if (start) begin
                    state_d = DIV_BUSY;
                    cnt_d   = '0;
                    quo_d   = abs_a;
                    rem_d   = '0;
                    dsr_d   = abs_b;
                    dvd_d   = dividend;
                    dz_d    = (divisor == '0);
                    ovf_d   = signed_op && (dividend == {1'b1, {(DBITS-1){1'b0}}})
                              && (divisor == '1);
                    q_neg_d = (a_neg ^ b_neg) && (divisor != '0);
                    r_neg_d = a_neg;
                end
            end
            DIV_BUSY: begin
                if (rem_diff[DBITS]) begin
                    rem_d = rem_shift[DBITS-1:0];
                    quo_d = {quo_q[DBITS-2:0], 1'b0};
                end else begin
                    rem_d = rem_diff[DBITS-1:0];
                    quo_d = {quo_q[DBITS-2:0], 1'b1};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DIV_ITERS-1)) state_d = DIV_DONE;
            end
            DIV_DONE: state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dsr_q   <= '0;
            dvd_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dsr_q   <= dsr_d;
            dvd_q   <= dvd_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == DIV_BUSY);
    assign done = (state_q == DIV_DONE);

    // Sign fix-up; the special cases override the magnitude result.
    assign quotient  = dz_q  ? '1 :
                       ovf_q ? {1'b1, {(DBITS-1){1'b0}}} :
                       (q_neg_q ? -quo_q : quo_q);
    assign remainder = dz_q  ? dvd_q :
                       ovf_q ? '0 :
                       (r_neg_q ? -rem_q : rem_q);

endmodule

// File: rtl/agex_stage.sv
// agex_stage: address-generate / execute stage.
//   Inputs  in_*        : DE latch contents (held stable while stall_out=1)
//   Outputs stall_out   : hold DE and FE (divide in flight)
//           br_redirect : taken branch/jump this cycle; br_target is the new PC
//           out_*       : registered AGEX latch for MEM_STAGE
module agex_stage
    import agex_stage_pkg::*;
#(
    parameter int DBITS     = 32,
    parameter int REGNOBITS = 5,
    parameter int IOPBITS   = 5,
    parameter int DIV_ITERS = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [IOPBITS-1:0]   in_op,
    input  logic [31:0]          in_inst,
    input  logic [DBITS-1:0]     in_pc,
    input  logic [DBITS-1:0]     in_inst_count,
    input  logic [DBITS-1:0]     in_rs1_val,
    input  logic [DBITS-1:0]     in_rs2_val,
    input  logic [DBITS-1:0]     in_imm,
    input  logic [REGNOBITS-1:0] in_rd,
    input  logic                 in_wr_reg,
    output logic                 stall_out,
    output logic                 br_redirect,
    output logic [DBITS-1:0]     br_target,
    output logic                 out_valid,
    output logic [31:0]          out_inst,
    output logic [DBITS-1:0]     out_pc,
    output logic [IOPBITS-1:0]   out_op,
    output logic [DBITS-1:0]     out_inst_count,
    output logic [DBITS-1:0]     out_aluout,
    output logic [DBITS-1:0]     out_memaddr,
    output logic [DBITS-1:0]     out_wr_val,
    output logic                 out_wr_mem,
    output logic                 out_rd_mem,
    output logic [REGNOBITS-1:0] out_rd,
    output logic                 out_wr_reg
);
    localparam int SHW = $clog2(DBITS);

    agex_latch_t latch_q, latch_d;

    logic             is_div, signed_div, div_start, div_busy, div_done;
    logic [DBITS-1:0] div_quo, div_rem;
    logic [DBITS-1:0] a, b, alu_res, addr_sum, pc_imm, pc_link;
    logic [SHW-1:0]   shamt;
    logic             taken;

    assign a        = in_rs1_val;
    assign b        = in_rs2_val;
    assign shamt    = b[SHW-1:0];
    assign addr_sum = a + in_imm;
    assign pc_imm   = in_pc + in_imm;
    assign pc_link  = in_pc + DBITS'(4);

    assign is_div     = is_div_op(in_op);
    assign signed_div = (in_op == OP_DIV) || (in_op == OP_REM);
    assign div_start  = in_valid & is_div & ~div_busy & ~div_done;

    // Stall through IDLE and BUSY; the DONE cycle lets the result through.
    assign stall_out   = in_valid & is_div & ~div_done;
    assign br_redirect = in_valid & taken & ~stall_out;
    assign br_target   = (in_op == OP_JALR) ? {addr_sum[DBITS-1:1], 1'b0} : pc_imm;

    agex_divider #(
        .DBITS     (DBITS),
        .DIV_ITERS (DIV_ITERS)
    ) u_div (
        .clk       (clk),
        .rst_n     (reset),
        .start     (div_start),
        .signed_op (signed_div),
        .dividend  (a),
        .divisor   (b),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_comb begin
        alu_res = '0;
        taken   = 1'b0;
        case (in_op)
            OP_ADD:   alu_res = a + b;
            OP_SUB:   alu_res = a - b;
            OP_AND:   alu_res = a & b;
            OP_OR:    alu_res = a | b;
            OP_XOR:   alu_res = a ^ b;
            OP_SLT:   alu_res = {{(DBITS-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU:  alu_res = {{(DBITS-1){1'b0}}, (a < b)};
            OP_SLL:   alu_res = a << shamt;
            OP_SRL:   alu_res = a >> shamt;
            OP_SRA:   alu_res = $signed(a) >>> shamt;
            OP_LUI:   alu_res = in_imm;
            OP_AUIPC: alu_res = pc_imm;
            OP_LW,
            OP_SW:    alu_res = addr_sum;
            OP_BEQ:   taken = (a == b);
            OP_BNE:   taken = (a != b);
            OP_BLT:   taken = ($signed(a) <  $signed(b));
            OP_BGE:   taken = ($signed(a) >= $signed(b));
            OP_BLTU:  taken = (a <  b);
            OP_BGEU:  taken = (a >= b);
            OP_JAL,
            OP_JALR: begin
                alu_res = pc_link;
                taken   = 1'b1;
            end
            OP_DIV,
            OP_DIVU:  alu_res = div_quo;
            OP_REM,
            OP_REMU:  alu_res = div_rem;
            default:  alu_res = '0;
        endcase
    end

    // Invalid input or a stall cycle both load an all-zero bubble.
    always_comb begin
        latch_d = '0;
        if (in_valid && !stall_out) begin
            latch_d.valid      = 1'b1;
            latch_d.inst       = in_inst;
            latch_d.pc         = in_pc;
            latch_d.op         = in_op;
            latch_d.inst_count = in_inst_count;
            latch_d.aluout     = alu_res;
            latch_d.memaddr    = addr_sum;
            latch_d.wr_val     = b;
            latch_d.wr_mem     = (in_op == OP_SW);
            latch_d.rd_mem     = (in_op == OP_LW);
            latch_d.rd         = in_rd;
            latch_d.wr_reg     = in_wr_reg;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) latch_q <= '0;
        else        latch_q <= latch_d;
    end

    assign out_valid      = latch_q.valid;
    assign out_inst       = latch_q.inst;
    assign out_pc         = latch_q.pc;
    assign out_op         = latch_q.op;
    assign out_inst_count = latch_q.inst_count;
    assign out_aluout     = latch_q.aluout;
    assign out_memaddr    = latch_q.memaddr;
    assign out_wr_val     = latch_q.wr_val;
    assign out_wr_mem     = latch_q.wr_mem;
    assign out_rd_mem     = latch_q.rd_mem;
    assign out_rd         = latch_q.rd;
    assign out_wr_reg     = latch_q.wr_reg;

endmodule

// File: tb/tb_agex_stage.sv
module tb_agex_stage;
    import agex_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid, in_wr_reg;
    logic [4:0]  in_op, in_rd;
    logic [31:0] in_inst, in_pc, in_inst_count, in_rs1_val, in_rs2_val, in_imm;
    logic        stall_out, br_redirect, out_valid, out_wr_mem, out_rd_mem, out_wr_reg;
    logic [31:0] br_target, out_inst, out_pc, out_inst_count, out_aluout, out_memaddr, out_wr_val;
    logic [4:0]  out_op, out_rd;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    agex_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_op(in_op), .in_inst(in_inst),
        .in_pc(in_pc), .in_inst_count(in_inst_count), .in_rs1_val(in_rs1_val),
        .in_rs2_val(in_rs2_val), .in_imm(in_imm), .in_rd(in_rd), .in_wr_reg(in_wr_reg),
        .stall_out(stall_out), .br_redirect(br_redirect), .br_target(br_target),
        .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc), .out_op(out_op),
        .out_inst_count(out_inst_count), .out_aluout(out_aluout), .out_memaddr(out_memaddr),
        .out_wr_val(out_wr_val), .out_wr_mem(out_wr_mem), .out_rd_mem(out_rd_mem),
        .out_rd(out_rd), .out_wr_reg(out_wr_reg)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model (architectural rules) ----------------
    function automatic logic [31:0] ref_result(input op_e op, input logic [31:0] a, b, imm, pc);
        int sa, sb, sr;
        sa = a;
        sb = b;
        case (op)
            OP_ADD:   return a + b;
            OP_SUB:   return a - b;
            OP_AND:   return a & b;
            OP_OR:    return a | b;
            OP_XOR:   return a ^ b;
            OP_SLT:   return (sa < sb) ? 32'd1 : 32'd0;
            OP_SLTU:  return (a < b) ? 32'd1 : 32'd0;
            OP_SLL:   return a << (b % 32);
            OP_SRL:   return a >> (b % 32);
            OP_SRA:   begin sr = sa >>> (b % 32); return sr; end
            OP_LUI:   return imm;
            OP_AUIPC: return pc + imm;
            OP_JAL, OP_JALR: return pc + 32'd4;
            OP_DIVU:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
            OP_REMU:  return (b == 0) ? a : a % b;
            OP_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                sr = sa / sb;
                return sr;
            end
            OP_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                sr = sa % sb;
                return sr;
            end
            default:  return 32'd0;
        endcase
    endfunction

    function automatic logic ref_taken(input op_e op, input logic [31:0] a, b);
        int sa, sb;
        sa = a;
        sb = b;
        case (op)
            OP_BEQ:  return a == b;
            OP_BNE:  return a != b;
            OP_BLT:  return sa < sb;
            OP_BGE:  return sa >= sb;
            OP_BLTU: return a < b;
            OP_BGEU: return a >= b;
            OP_JAL, OP_JALR: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic writes_rd(input op_e op);
        return !(op inside {OP_SW, OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU});
    endfunction

    function automatic logic has_result(input op_e op);
        return writes_rd(op) && op != OP_LW;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive(input op_e op, input logic [31:0] a, b, imm, pc);
        in_valid      = 1'b1;
        in_op         = op;
        in_inst       = $urandom;
        in_pc         = pc;
        in_inst_count = $urandom;
        in_rs1_val    = a;
        in_rs2_val    = b;
        in_imm        = imm;
        in_rd         = 5'($urandom_range(1, 31));
        in_wr_reg     = writes_rd(op);
    endtask

    task automatic run_op(input op_e op, input logic [31:0] a, b, imm, pc);
        logic        tk;
        logic [31:0] tgt, res, inst, icnt;
        logic [4:0]  rd;
        drive(op, a, b, imm, pc);
        inst = in_inst; icnt = in_inst_count; rd = in_rd;
        tk  = ref_taken(op, a, b);
        tgt = (op == OP_JALR) ? ((a + imm) & 32'hFFFF_FFFE) : pc + imm;
        res = ref_result(op, a, b, imm, pc);
        @(negedge clk);
        chk("stall", stall_out, 0);
        chk("redirect", br_redirect, tk);
        if (tk) chk("target", br_target, tgt);
        @(posedge clk); #1;
        chk("valid", out_valid, 1);
        chk("op", out_op, op);
        chk("pc", out_pc, pc);
        chk("inst", out_inst, inst);
        chk("inst_count", out_inst_count, icnt);
        chk("rd", out_rd, rd);
        chk("wr_reg", out_wr_reg, writes_rd(op));
        chk("wr_mem", out_wr_mem, op == OP_SW);
        chk("rd_mem", out_rd_mem, op == OP_LW);
        if (has_result(op)) chk("aluout", out_aluout, res);
        if (op == OP_LW || op == OP_SW) chk("memaddr", out_memaddr, a + imm);
        if (op == OP_SW) chk("wr_val", out_wr_val, b);
    endtask

    task automatic run_div(input op_e op, input logic [31:0] a, b);
        int          stalls, bad;
        logic [31:0] exp;
        logic [4:0]  rd;
        exp = ref_result(op, a, b, 32'd0, 32'd0);
        drive(op, a, b, 32'd0, 32'h200);
        rd = in_rd;
        stalls = 0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!stall_out) break;
            stalls++;
            if (br_redirect) bad++;
            @(posedge clk); #1;
            if (out_valid || out_wr_reg || out_wr_mem) bad++;
        end
        chk("div_stall_cycles", stalls, 33);
        chk("div_bubbles", bad, 0);
        @(posedge clk); #1;
        chk("div_valid", out_valid, 1);
        chk("div_result", out_aluout, exp);
        chk("div_wr_reg", out_wr_reg, 1);
        chk("div_rd", out_rd, rd);
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        in_op = $urandom_range(1, 22);
        in_wr_reg = 1'b1;
        in_rs1_val = $urandom;
        in_rs2_val = in_rs1_val;
        @(negedge clk);
        chk("idle_redirect", br_redirect, 0);
        chk("idle_stall", stall_out, 0);
        @(posedge clk); #1;
        chk("idle_valid", out_valid, 0);
        chk("idle_wr_reg", out_wr_reg, 0);
        chk("idle_wr_mem", out_wr_mem, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        in_valid = 0; in_op = 0; in_inst = 0; in_pc = 0; in_inst_count = 0;
        in_rs1_val = 0; in_rs2_val = 0; in_imm = 0; in_rd = 0; in_wr_reg = 0;
        #1 reset = 1'b0;
        #2;
        chk("reset_valid", out_valid, 0);
        chk("reset_aluout", out_aluout, 0);
        chk("reset_wr_reg", out_wr_reg, 0);
        chk("reset_pc", out_pc, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;

        // directed cases
        run_op(OP_ADD, 32'h7FFF_FFFF, 32'd1, 32'd0, 32'h40);
        run_op(OP_BEQ, 32'd55, 32'd55, 32'hFFFF_FFF8, 32'h100);
        run_op(OP_BEQ, 32'd55, 32'd56, 32'hFFFF_FFF8, 32'h100);
        run_op(OP_SW, 32'h1000, 32'hDEAD, 32'd4, 32'h104);
        run_op(OP_JALR, 32'h2003, 32'd0, 32'd8, 32'h108);
        run_op(OP_SRA, 32'h8000_0000, 32'h0000_0123, 32'd0, 32'h10C);
        run_div(OP_DIV,  32'hFFFF_FFF9, 32'd2);
        run_div(OP_REM,  32'hFFFF_FFF9, 32'd2);
        run_div(OP_DIVU, 32'd5, 32'd0);
        run_div(OP_REM,  32'd5, 32'd0);
        run_div(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF);
        run_div(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF);
        run_op(OP_ADD, 32'd1, 32'd2, 32'd0, 32'h110);
        idle_cycle();

        // async reset on a populated latch
        run_op(OP_OR, 32'hF0F0_0000, 32'h0000_0F0F, 32'd0, 32'h120);
        #2 reset = 1'b0;
        #1;
        chk("async_valid", out_valid, 0);
        chk("async_aluout", out_aluout, 0);
        chk("async_pc", out_pc, 0);
        in_valid = 1'b0;
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;

        // reset in the middle of a division
        drive(OP_DIV, 32'd1000, 32'd3, 32'd0, 32'h300);
        repeat (11) @(posedge clk);
        #2 reset = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("midreset_valid", out_valid, 0);
        chk("midreset_aluout", out_aluout, 0);
        chk("midreset_stall", stall_out, 0);
        @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_valid", out_valid, 0);
        run_div(OP_DIVU, 32'd100, 32'd7);

        // randomized single-cycle ops, interleaved with bubbles and divides
        for (int i = 0; i < 80; i++) begin
            op_e         op;
            logic [31:0] a, b;
            op = op_e'($urandom_range(1, 22));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 40);
            run_op(op, a, b, $urandom, $urandom);
            if ($urandom_range(0, 9) == 0) idle_cycle();
        end
        for (int i = 0; i < 8; i++) begin
            op_e         op;
            logic [31:0] a, b;
            op = op_e'($urandom_range(23, 26));
            a  = $urandom;
            case ($urandom_range(0, 4))
                0:       b = 32'd0;
                1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2:       b = $urandom_range(1, 100);
                default: b = $urandom;
            endcase
            run_div(op, a, b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/agex_stage.md
Name: agex_stage

Overview:
- Address-generate/execute stage of the 5-stage RV32 pipeline. Sits between the DE latch and MEM_STAGE.
- Performs ALU ops, branch/jump resolution, load/store address generation and store-data forwarding.
- Adds an iterative 32-cycle divider for DIV/DIVU/REM/REMU. The divider stalls DE/FE while busy.
- Output is a registered AGEX latch that MEM_STAGE consumes.

Parameters:
- DBITS, 32, datapath width
- REGNOBITS, 5, register index width
- IOPBITS, 5, internal opcode width (encodings in shared package)
- DIV_ITERS, 32, divider iteration count; must equal DBITS

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- in_valid  in  1  DE latch holds a valid instruction
- in_op  in  IOPBITS  decoded opcode
- in_inst  in  32  raw instruction, passed through
- in_pc  in  DBITS  instruction PC
- in_inst_count  in  DBITS  retire counter tag, passed through
- in_rs1_val  in  DBITS  operand A
- in_rs2_val  in  DBITS  operand B
- in_imm  in  DBITS  sign-extended immediate
- in_rd  in  REGNOBITS  destination register
- in_wr_reg  in  1  writes rd
- stall_out  out  1  hold DE latch and FE PC this cycle
- br_redirect  out  1  taken branch/jump; FE loads br_target and DE squashes
- br_target  out  DBITS  redirect PC
- out_valid  out  1  latch valid
- out_inst, out_pc, out_op, out_inst_count  out  passthrough widths  registered copies
- out_aluout  out  DBITS  result (or link PC+4)
- out_memaddr  out  DBITS  rs1+imm for LW/SW
- out_wr_val  out  DBITS  store data (rs2)
- out_wr_mem  out  1  store enable
- out_rd_mem  out  1  load
- out_rd  out  REGNOBITS  destination register
- out_wr_reg  out  1  register write enable

Behaviour:
- Reset (reset==0, async): all out_* = 0; divider returns to IDLE; its counter and partial results are cleared.
- Reset mid-division aborts the division. After release the stage restarts clean.
- Single-cycle ops: ADD SUB AND OR XOR SLT SLTU SLL SRL SRA LUI AUIPC, loads/stores, branches, JAL, JALR.
  - Computed combinationally from in_*.
  - Captured into the out latch at the next posedge.
  - Latency 1 cycle.
- Shifts use operand B bits [4:0].
- SLT is signed; SLTU is unsigned.
- LUI: result = imm. AUIPC: result = pc+imm.
- JAL: br_target = pc+imm. JALR: br_target = (rs1+imm) & ~1. Both write pc+4 to out_aluout.
- Branches BEQ BNE BLT BGE BLTU BGEU: when taken, br_target = pc+imm.
- br_redirect = in_valid & taken & !stall_out. It is combinational and asserted in the same cycle the branch sits in AGEX.
- Divider FSM states: IDLE, BUSY, DONE.
  - IDLE→BUSY when in_valid & div-class op. Operands are captured as absolute values, with sign flags for DIV/REM; counter = 0.
  - BUSY: one restoring-division step per cycle; counter += 1; after counter reaches DIV_ITERS-1, go to DONE.
  - DONE: sign fix-up applied; result is written to the out latch at this edge; return to IDLE.
  - Total: a div op presented at cycle k is in the out latch after edge k+33.
- stall_out = in_valid & div-class & (state != DONE). The DE latch stays stable throughout.
- While stall_out=1, the out latch captures a bubble (out_valid=0, out_wr_reg=0, out_wr_mem=0).
- Special cases, handled in fix-up with the same fixed latency:
  - Divide by zero: quotient = all-ones; remainder = dividend.
  - Signed overflow 0x80000000 / -1: quotient = 0x80000000; remainder = 0.
- Remainder takes the sign of the dividend. Quotient is negative iff operand signs differ and the divisor is nonzero.
- in_valid=0 produces a bubble; out_valid is cleared and all enables are 0.
- All arithmetic is mod 2^DBITS. Address/PC adds wrap silently.
- A div op immediately followed by another div: the second starts from IDLE on the cycle after DONE, so there are no back-to-back overlaps.

Decomposition:
- Shared package/define header holds:
  - opcode encodings (OP_ADD…OP_REMU) and the div-class predicate;
  - AGEX latch width and field order, matching the MEM_STAGE unpack order: valid, inst, pc, op, inst_count, aluout, memaddr, wr_val, wr_mem, rd_mem, rd, wr_reg.
- One sub-module: agex_divider (FSM, counter, restoring datapath, fix-up), with handshake start/busy/done/quotient/remainder.

Test Plan:
- ADD rs1=0x7FFFFFFF, rs2=1 → out_aluout=0x80000000, out_valid=1 one cycle later, stall_out=0.
- BEQ pc=0x100, imm=-8, rs1==rs2 → br_redirect=1, br_target=0x0F8 same cycle. With rs1≠rs2 → br_redirect=0.
- DIV with each special case; each must show stall_out high 33 cycles, then valid in the latch after edge k+33, with bubbles in between:
  - rs1=-7, rs2=2 → quotient 0xFFFFFFFD.
  - REM same operands → 0xFFFFFFFF.
- DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5; DIV 0x80000000/-1 → 0x80000000; REM → 0.
- SW rs1=0x1000, imm=4, rs2=0xDEAD → out_memaddr=0x1004, out_wr_val=0xDEAD, out_wr_mem=1, out_wr_reg=0.
- Assert reset low at iteration 10 of a DIV → all outputs 0 immediately (async). After release with in_valid=0 the FSM is IDLE. A fresh DIVU 100/7 yields 14 after 33 cycles.
